// File: rtl/display_arb_pkg.sv
// Shared types and constants for the two-requester display arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package display_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int NUM_REQ  = 2;
    localparam int NIBBLE_W = 4;

    // One-hot grant vector for a state; IDLE maps to no owner.
    function automatic logic [NUM_REQ-1:0] grant_of(input arb_state_t s);
        logic [NUM_REQ-1:0] g;
        g = '0;
        case (s)
            GNT0:    g = 2'b01;
            GNT1:    g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Minimum-dwell countdown in divided-clock ticks; expired while the count is zero.
// Latency: load/decrement visible one clk later; expired is a registered condition.
// Backpressure: hold freezes the count; load overrides tick and hold.
module dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    input  logic             hold,
    output logic             expired
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && !hold && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the two-digit display path with minimum dwell and freeze.
// Latency: 1 clk from req/data to grant, nibbles, blank and swap (all registered).
// Backpressure: freeze pins state, grant, dwell and displayed nibbles.
module display_arbiter
    import display_arb_pkg::*;
#(
    parameter int DWELL_TICKS = 4,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [7:0]          data0,
    input  logic [7:0]          data1,
    input  logic                freeze,
    output logic [NUM_REQ-1:0]  grant,
    output logic [NIBBLE_W-1:0] nibble_ms,
    output logic [NIBBLE_W-1:0] nibble_ls,
    output logic                blank,
    output logic                swap
);

    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_TICKS);

    arb_state_t state, state_nxt;
    logic       rr_last;
    logic       expired;
    logic       dwell_load;
    logic       pick_vld;
    logic       pick_id;
    logic       own;
    logic       oth;
    logic [7:0] nxt_dat;

    dwell_timer #(.CNT_W(CNT_W)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (dwell_load),
        .load_val (DWELL_LD),
        .tick     (tick),
        .hold     (freeze),
        .expired  (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            grant     <= '0;
            nibble_ms <= '0;
            nibble_ls <= '0;
            blank     <= 1'b1;
            swap      <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_of(state_nxt);
            swap  <= (state_nxt != state);
            blank <= (state_nxt == IDLE);
            // The owner being released becomes the lowest priority.
            if ((state != IDLE) && (state_nxt != state)) begin
                rr_last <= (state == GNT1);
            end
            if (state_nxt == IDLE) begin
                nibble_ms <= '0;
                nibble_ls <= '0;
            end else if (!freeze) begin
                nibble_ms <= nxt_dat[7:4];
                nibble_ls <= nxt_dat[3:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pick_vld  = 1'b0;
        pick_id   = 1'b0;
        own       = (state == GNT1);
        oth       = ~own;

        if (req[~rr_last]) begin
            pick_vld = 1'b1;
            pick_id  = ~rr_last;
        end else if (req[rr_last]) begin
            pick_vld = 1'b1;
            pick_id  = rr_last;
        end

        if (!freeze) begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state_nxt = pick_id ? GNT1 : GNT0;
                    end
                end
                GNT0, GNT1: begin
                    if (!req[own]) begin
                        state_nxt = req[oth] ? (oth ? GNT1 : GNT0) : IDLE;
                    end else if (expired && req[oth]) begin
                        state_nxt = oth ? GNT1 : GNT0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Reload on any new grant, and when an expired owner keeps the display uncontested.
    assign dwell_load = (state_nxt != IDLE) &&
                        ((state_nxt != state) || (expired && !freeze));
    assign nxt_dat    = (state_nxt == GNT1) ? data1 : data0;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: DWELL_TICKS=4 and DWELL_TICKS=0 instances share stimulus.
// Latency: n/a. Backpressure: n/a.
module tb_display_arbiter;

    logic       clk = 1'b0;
    logic       rst, tick, freeze;
    logic [1:0] req;
    logic [7:0] data0, data1;

    logic [1:0] grant_a, grant_b;
    logic [3:0] ms_a, ls_a, ms_b, ls_b;
    logic       blank_a, blank_b, swap_a, swap_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    display_arbiter #(.DWELL_TICKS(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .req(req), .data0(data0), .data1(data1),
        .freeze(freeze), .grant(grant_a), .nibble_ms(ms_a), .nibble_ls(ls_a),
        .blank(blank_a), .swap(swap_a)
    );

    display_arbiter #(.DWELL_TICKS(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .req(req), .data0(data0), .data1(data1),
        .freeze(freeze), .grant(grant_b), .nibble_ms(ms_b), .nibble_ls(ls_b),
        .blank(blank_b), .swap(swap_b)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: owner is -1 (none), 0 or 1; dwell is a plain integer count of ticks left.
    int       dw[2] = '{4, 0};
    int       m_own[2], m_dwell[2], m_rr[2];
    bit [3:0] m_ms[2], m_ls[2];
    bit       m_blank[2], m_swap[2];
    bit       m_valid = 1'b0;

    task automatic model_step(input int i);
        int nxt, x, o, p;
        if (rst) begin
            m_own[i] = -1; m_dwell[i] = 0; m_rr[i] = 1;
            m_ms[i] = 0; m_ls[i] = 0; m_blank[i] = 1; m_swap[i] = 0;
        end else begin
            nxt = m_own[i];
            if (!freeze) begin
                if (m_own[i] < 0) begin
                    o = 1 - m_rr[i];
                    p = req[o] ? o : (req[m_rr[i]] ? m_rr[i] : -1);
                    if (p >= 0) begin
                        nxt = p;
                        m_dwell[i] = dw[i];
                    end
                end else begin
                    x = m_own[i];
                    o = 1 - x;
                    if (!req[x]) begin
                        m_rr[i] = x;
                        nxt = req[o] ? o : -1;
                        if (nxt >= 0) m_dwell[i] = dw[i];
                    end else if (m_dwell[i] == 0 && req[o]) begin
                        m_rr[i] = x;
                        nxt = o;
                        m_dwell[i] = dw[i];
                    end else if (m_dwell[i] == 0) begin
                        m_dwell[i] = dw[i];
                    end else if (tick) begin
                        m_dwell[i] = m_dwell[i] - 1;
                    end
                end
            end
            m_swap[i] = (nxt != m_own[i]);
            m_own[i]  = nxt;
            if (m_own[i] < 0) begin
                m_ms[i] = 0; m_ls[i] = 0; m_blank[i] = 1;
            end else if (!freeze) begin
                m_ms[i] = (m_own[i] == 1) ? data1[7:4] : data0[7:4];
                m_ls[i] = (m_own[i] == 1) ? data1[3:0] : data0[3:0];
                m_blank[i] = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
        if (rst) m_valid = 1'b1;
    end

    function automatic logic [1:0] exp_grant(input int own);
        return (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("a_grant", 8'(grant_a), 8'(exp_grant(m_own[0])));
            chk("a_ms",    8'(ms_a),    8'(m_ms[0]));
            chk("a_ls",    8'(ls_a),    8'(m_ls[0]));
            chk("a_blank", 8'(blank_a), 8'(m_blank[0]));
            chk("a_swap",  8'(swap_a),  8'(m_swap[0]));
            chk("b_grant", 8'(grant_b), 8'(exp_grant(m_own[1])));
            chk("b_ms",    8'(ms_b),    8'(m_ms[1]));
            chk("b_ls",    8'(ls_b),    8'(m_ls[1]));
            chk("b_blank", 8'(blank_b), 8'(m_blank[1]));
            chk("b_swap",  8'(swap_b),  8'(m_swap[1]));
            chk("a_not_11", 8'(grant_a == 2'b11), 8'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            tick = 1'b1;
            step(1);
            tick = 1'b0;
            step(1);
        end
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; tick = 1'b0; freeze = 1'b0;
        data0 = 8'h00; data1 = 8'h00;
        step(2);
        chk("rst_grant", 8'(grant_a), 8'h00);
        chk("rst_blank", 8'(blank_a), 8'h01);
        chk("rst_swap",  8'(swap_a),  8'h00);
        chk("rst_nib",   {ms_a, ls_a}, 8'h00);
        rst = 1'b0;

        // First grant, 1-clk latency
        data0 = 8'hA5; req = 2'b01;
        step(1);
        chk("t1_grant", 8'(grant_a), 8'h01);
        chk("t1_nib",   {ms_a, ls_a}, 8'hA5);
        chk("t1_blank", 8'(blank_a), 8'h00);
        chk("t1_swap",  8'(swap_a),  8'h01);
        step(1);
        chk("t1_swap_low", 8'(swap_a), 8'h00);
        req = 2'b00;
        step(1);
        chk("t1_idle", 8'(grant_a), 8'h00);

        // Contention from reset; instance B alternates every clk
        rst = 1'b1; step(1); rst = 1'b0;
        data1 = 8'h96; req = 2'b11;
        step(1);
        chk("t2_first",   8'(grant_a), 8'h01);
        chk("t2_b_first", 8'(grant_b), 8'h01);
        step(1);
        chk("t2_b_alt1",  8'(grant_b), 8'h02);
        chk("t2_b_swap1", 8'(swap_b),  8'h01);
        step(1);
        chk("t2_b_alt2",  8'(grant_b), 8'h01);
        chk("t2_b_swap2", 8'(swap_b),  8'h01);
        tick_n(3);
        chk("t2_hold3", 8'(grant_a), 8'h01);
        tick = 1'b1; step(1); tick = 1'b0;
        chk("t2_tick4_nosw", 8'(grant_a), 8'h01);
        step(1);
        chk("t2_sw_grant", 8'(grant_a), 8'h02);
        chk("t2_sw_swap",  8'(swap_a),  8'h01);
        chk("t2_sw_nib",   {ms_a, ls_a}, 8'h96);
        step(1);
        chk("t2_swap_low", 8'(swap_a), 8'h00);
        tick_n(3);
        tick = 1'b1; step(1); tick = 1'b0;
        chk("t2_back_nosw", 8'(grant_a), 8'h02);
        step(1);
        chk("t2_back_grant", 8'(grant_a), 8'h01);
        chk("t2_back_swap",  8'(swap_a),  8'h01);

        // Early release with dwell 3
        tick_n(1);
        req = 2'b10;
        step(1);
        chk("t3_rel_grant", 8'(grant_a), 8'h02);
        chk("t3_rel_nib",   {ms_a, ls_a}, 8'h96);
        req = 2'b00;
        step(1);
        chk("t3_idle_grant", 8'(grant_a), 8'h00);
        chk("t3_idle_blank", 8'(blank_a), 8'h01);
        chk("t3_idle_nib",   {ms_a, ls_a}, 8'h00);

        // Freeze holds grant, nibbles and dwell
        data1 = 8'h3C; req = 2'b10;
        step(1);
        chk("t4_grant", 8'(grant_a), 8'h02);
        chk("t4_nib",   {ms_a, ls_a}, 8'h3C);
        tick_n(1);
        freeze = 1'b1; req = 2'b11; data1 = 8'hFF;
        tick_n(10);
        chk("t4_frz_grant", 8'(grant_a), 8'h02);
        chk("t4_frz_nib",   {ms_a, ls_a}, 8'h3C);
        freeze = 1'b0;
        step(1);
        chk("t4_thaw_nib",   {ms_a, ls_a}, 8'hFF);
        chk("t4_thaw_grant", 8'(grant_a), 8'h02);
        tick_n(2);
        chk("t4_resume_hold", 8'(grant_a), 8'h02);
        tick_n(1);
        chk("t4_resume_sw", 8'(grant_a), 8'h01);

        // Reset mid-grant in GNT1 with dwell 2
        tick_n(4);
        chk("t5_gnt1", 8'(grant_a), 8'h02);
        tick_n(2);
        rst = 1'b1;
        step(1);
        chk("t5_rst_grant", 8'(grant_a), 8'h00);
        chk("t5_rst_nib",   {ms_a, ls_a}, 8'h00);
        chk("t5_rst_blank", 8'(blank_a), 8'h01);
        chk("t5_rst_swap",  8'(swap_a),  8'h00);
        rst = 1'b0;
        step(1);
        chk("t5_after_grant", 8'(grant_a), 8'h01);
        chk("t5_after_swap",  8'(swap_a),  8'h01);

        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
